// File: rtl/scan_decoder.sv
// One-hot decoder with direct (handshaked index) and optional scan modes.
// Scan mode is compiled only when SCAN_DECODER_SCAN_EN is defined.
module scan_decoder #(
  parameter int unsigned SEL_W = 3,
  parameter int unsigned DWELL = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  in_valid,
  input  logic [SEL_W-1:0]      in_sel,
  output logic                  in_ready,
  output logic [2**SEL_W-1:0]   out,
  output logic                  out_valid,
  output logic                  scan_wrap
);

  localparam int unsigned N = 2**SEL_W;
  localparam logic [N-1:0] OneHot0 = N'(1);

  if (SEL_W < 1 || SEL_W > 6) begin : g_bad_sel_w
    $error("SEL_W out of range");
  end
  if (DWELL < 1 || DWELL > 65535) begin : g_bad_dwell
    $error("DWELL out of range");
  end

`ifdef SCAN_DECODER_SCAN_EN
  typedef enum logic [1:0] {StIdle, StDirect, StScan} state_e;
  localparam logic [15:0]      DwellMax = 16'(DWELL - 1);
  localparam logic [SEL_W-1:0] IdxMax   = '1;

  logic [SEL_W-1:0] idx_q, idx_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
`else
  typedef enum logic [1:0] {StIdle, StDirect} state_e;
`endif

  state_e         state_q, state_d;
  logic [N-1:0]   out_q, out_d;
  logic           out_valid_q, out_valid_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // en=0 dominates mode; without scan support mode=1 parks in idle
  always_comb begin
    state_d = StIdle;
    if (en) begin
      if (!mode) state_d = StDirect;
`ifdef SCAN_DECODER_SCAN_EN
      else       state_d = StScan;
`endif
    end
  end

  assign in_ready = (state_q == StDirect) && en && !mode;

  always_comb begin
    out_d       = '0;
    out_valid_d = 1'b0;
`ifdef SCAN_DECODER_SCAN_EN
    idx_d       = '0;
    cnt_d       = '0;
    wrap_d      = 1'b0;
`endif
    case (state_d)
      StDirect: begin
        // Entering direct mode clears the output until a transfer lands
        if (state_q == StDirect) begin
          out_d       = out_q;
          out_valid_d = out_valid_q;
          if (in_valid && in_ready) begin
            out_d       = OneHot0 << in_sel;
            out_valid_d = 1'b1;
          end
        end
      end
`ifdef SCAN_DECODER_SCAN_EN
      StScan: begin
        out_valid_d = 1'b1;
        if (state_q != StScan) begin
          out_d = OneHot0;
        end else if (cnt_q == DwellMax) begin
          idx_d  = idx_q + 1'b1;
          out_d  = OneHot0 << idx_d;
          wrap_d = (idx_q == IdxMax);
        end else begin
          idx_d = idx_q;
          cnt_d = cnt_q + 16'd1;
          out_d = out_q;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
`ifdef SCAN_DECODER_SCAN_EN
      idx_q       <= '0;
      cnt_q       <= '0;
      wrap_q      <= 1'b0;
`endif
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
`ifdef SCAN_DECODER_SCAN_EN
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      wrap_q      <= wrap_d;
`endif
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
`ifdef SCAN_DECODER_SCAN_EN
  assign scan_wrap = wrap_q;
`else
  assign scan_wrap = 1'b0;
`endif

endmodule

// File: tb/tb_scan_decoder.sv
// Directed self-checking bench for scan_decoder (SEL_W=3, DWELL=2).
// Scan scenarios run only when SCAN_DECODER_SCAN_EN is defined.
module tb_scan_decoder;

  logic       clk = 1'b0;
  logic       rst, en, mode, in_valid;
  logic [2:0] in_sel;
  logic       in_ready;
  logic [7:0] out;
  logic       out_valid, scan_wrap;

  int checks = 0;
  int errors = 0;

  scan_decoder #(.SEL_W(3), .DWELL(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_sel    (in_sel),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .scan_wrap (scan_wrap)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; en = 1; mode = 0; in_valid = 1; in_sel = 3'd5;
    step();
    checks++; if (out !== 8'h00) begin errors++; $display("FAIL reset_out got %h want 00", out); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_ov got %b want 0", out_valid); end
    checks++; if (scan_wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b want 0", scan_wrap); end
    rst = 0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_idle_ready got %b want 0", in_ready); end
    step();
    checks++; if (out !== 8'h00) begin errors++; $display("FAIL direct_entry_out got %h want 00", out); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL direct_entry_ready got %b want 1", in_ready); end
  endtask

  task automatic test_direct();
    logic [7:0] exp;
    in_valid = 1; in_sel = 3'd5;
    step();
    checks++; if (out !== 8'b0010_0000) begin errors++; $display("FAIL direct_sel5 got %h want 20", out); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL direct_sel5_ov got %b want 1", out_valid); end
    for (int i = 0; i < 8; i++) begin
      in_sel = 3'(i);
      step();
      exp = 8'h01 << i;
      checks++; if (out !== exp) begin errors++; $display("FAIL direct_b2b_%0d got %h want %h", i, out, exp); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL direct_b2b_ov_%0d got %b want 1", i, out_valid); end
    end
    in_valid = 0; in_sel = 3'd2;
    step();
    checks++; if (out !== 8'h80) begin errors++; $display("FAIL direct_hold got %h want 80", out); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL direct_hold_ov got %b want 1", out_valid); end
  endtask

  task automatic test_en_priority();
    in_valid = 1; in_sel = 3'd3;
    step();
    checks++; if (out !== 8'h08) begin errors++; $display("FAIL en_pre got %h want 08", out); end
    en = 0; in_sel = 3'd2;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL en_off_ready got %b want 0", in_ready); end
    step();
    checks++; if (out !== 8'h00) begin errors++; $display("FAIL en_off_out got %h want 00", out); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL en_off_ov got %b want 0", out_valid); end
    en = 1; in_valid = 0;
    step();
    checks++; if (out !== 8'h00) begin errors++; $display("FAIL en_back_out got %h want 00", out); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL en_back_ready got %b want 1", in_ready); end
  endtask

  task automatic test_rst_mid_transfer();
    rst = 1; in_valid = 1; in_sel = 3'd6;
    step();
    checks++; if (out !== 8'h00) begin errors++; $display("FAIL rst_xfer_out got %h want 00", out); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_xfer_ov got %b want 0", out_valid); end
    rst = 0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_xfer_ready got %b want 0", in_ready); end
    step();
    checks++; if (out !== 8'h00) begin errors++; $display("FAIL rst_xfer_entry got %h want 00", out); end
    step();
    checks++; if (out !== 8'h40) begin errors++; $display("FAIL rst_xfer_accept got %h want 40", out); end
  endtask

`ifdef SCAN_DECODER_SCAN_EN
  task automatic test_scan();
    logic [7:0] exp;
    rst = 1;
    step();
    rst = 0; en = 1; mode = 1; in_valid = 1; in_sel = 3'd3;
    for (int k = 0; k < 18; k++) begin
      step();
      exp = (k < 16) ? (8'h01 << (k / 2)) : 8'h01;
      checks++; if (out !== exp) begin errors++; $display("FAIL scan_out_%0d got %h want %h", k, out, exp); end
      checks++; if (scan_wrap !== (k == 16)) begin errors++; $display("FAIL scan_wrap_%0d got %b want %b", k, scan_wrap, k == 16); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL scan_ov_%0d got %b want 1", k, out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL scan_ready_%0d got %b want 0", k, in_ready); end
    end
  endtask

  task automatic test_scan_rst();
    rst = 1;
    step();
    rst = 0; en = 1; mode = 1; in_valid = 0;
    for (int k = 0; k < 9; k++) step();
    checks++; if (out !== 8'h10) begin errors++; $display("FAIL scan_rst_pre got %h want 10", out); end
    rst = 1;
    step();
    checks++; if (out !== 8'h00) begin errors++; $display("FAIL scan_rst_out got %h want 00", out); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL scan_rst_ov got %b want 0", out_valid); end
    rst = 0;
    step();
    checks++; if (out !== 8'h01) begin errors++; $display("FAIL scan_rst_restart got %h want 01", out); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL scan_rst_restart_ov got %b want 1", out_valid); end
  endtask

  task automatic test_mode_switch();
    rst = 1;
    step();
    rst = 0; en = 1; mode = 1; in_valid = 0;
    for (int k = 0; k < 5; k++) step();
    checks++; if (out !== 8'h04) begin errors++; $display("FAIL switch_pre got %h want 04", out); end
    mode = 0;
    step();
    checks++; if (out !== 8'h00) begin errors++; $display("FAIL switch_out got %h want 00", out); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL switch_ov got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL switch_ready got %b want 1", in_ready); end
    in_valid = 1; in_sel = 3'd7;
    step();
    checks++; if (out !== 8'h80) begin errors++; $display("FAIL switch_sel7 got %h want 80", out); end
  endtask
`else
  task automatic test_mode_idle();
    rst = 1;
    step();
    rst = 0; en = 1; mode = 1; in_valid = 1; in_sel = 3'd4;
    for (int k = 0; k < 20; k++) begin
      step();
      checks++; if (out !== 8'h00) begin errors++; $display("FAIL noscan_out_%0d got %h want 00", k, out); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL noscan_ov_%0d got %b want 0", k, out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL noscan_ready_%0d got %b want 0", k, in_ready); end
      checks++; if (scan_wrap !== 1'b0) begin errors++; $display("FAIL noscan_wrap_%0d got %b want 0", k, scan_wrap); end
    end
  endtask
`endif

  initial begin
    rst = 1; en = 0; mode = 0; in_valid = 0; in_sel = '0;
    #1;
    test_reset();
    test_direct();
    test_en_priority();
    test_rst_mid_transfer();
`ifdef SCAN_DECODER_SCAN_EN
    test_scan();
    test_scan_rst();
    test_mode_switch();
`else
    test_mode_idle();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
